// File: rtl/sch_dispatcher.sv
// sch_dispatcher: 1-to-8 stream distributor.
//
// A single destination-tagged valid/ready input stream is routed beat by beat
// into one of eight per-port FIFOs, or into all eight on broadcast. Each
// output port drains its own FIFO through a valid/ready handshake, so a
// stalled consumer only blocks beats addressed to its own port.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   valid_i, data_i,
//   priority_i, dest_i,
//   bcast_i             - input beat and its routing tag
//   ready_i (out)       - the presented beat can be accepted this cycle
//   channel_valid_o     - per-port valid (bit k = port k)
//   channel_data_o      - per-port head data, port k at [k*DATA_W +: DATA_W]
//   channel_priority_o  - per-port head priority, port k at [k*PRIO_W +: PRIO_W]
//   channel_ready_i     - per-port consumer ready
//   occupancy_o         - per-port fill level, port k at [k*OW +: OW]
//   accept_cnt_o        - wrapping count of accepted input beats
module sch_dispatcher #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PRIO_W = 3,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid_i,
    input  logic [DATA_W-1:0]                 data_i,
    input  logic [PRIO_W-1:0]                 priority_i,
    input  logic [2:0]                        dest_i,
    input  logic                              bcast_i,
    output logic                              ready_i,
    output logic [7:0]                        channel_valid_o,
    output logic [8*DATA_W-1:0]               channel_data_o,
    output logic [8*PRIO_W-1:0]               channel_priority_o,
    input  logic [7:0]                        channel_ready_i,
    output logic [8*($clog2(DEPTH)+1)-1:0]    occupancy_o,
    output logic [CNT_W-1:0]                  accept_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam int unsigned EW = DATA_W + PRIO_W;
    localparam logic [AW:0] PTR_ONE = OW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef logic [EW-1:0] entry_t;

    entry_t          mem [8][DEPTH];
    logic [AW:0]     wr_ptr_q [8];
    logic [AW:0]     rd_ptr_q [8];
    logic [CNT_W-1:0] cnt_q;

    logic [7:0] full;
    logic [7:0] empty;
    logic [7:0] push;
    logic [7:0] pop;
    logic       accept;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    always_comb begin
        full  = '0;
        empty = '0;
        for (int k = 0; k < 8; k++) begin
            empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            full[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                       (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
        end
    end

    // Acceptance looks only at stored fill state, never at channel_ready_i,
    // so a full FIFO refuses a push even while it is being popped.
    always_comb begin
        if (reset) begin
            ready_i = 1'b0;
        end else if (bcast_i) begin
            ready_i = (full == 8'h00);
        end else begin
            ready_i = !full[dest_i];
        end
    end

    assign accept = valid_i & ready_i;

    always_comb begin
        push = '0;
        pop  = '0;
        for (int k = 0; k < 8; k++) begin
            push[k] = accept & (bcast_i | (dest_i == 3'(k)));
            pop[k]  = ~empty[k] & channel_ready_i[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (push[k]) begin
                    wr_ptr_q[k] <= wr_ptr_q[k] + PTR_ONE;
                end
                if (pop[k]) begin
                    rd_ptr_q[k] <= rd_ptr_q[k] + PTR_ONE;
                end
            end
            if (accept) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    // Storage needs no reset; accept is already blocked while reset is high.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr_q[k][AW-1:0]] <= {data_i, priority_i};
            end
        end
    end

    always_comb begin
        channel_valid_o    = '0;
        channel_data_o     = '0;
        channel_priority_o = '0;
        occupancy_o        = '0;
        for (int k = 0; k < 8; k++) begin
            channel_valid_o[k] = ~empty[k];
            channel_data_o[k*DATA_W +: DATA_W] =
                mem[k][rd_ptr_q[k][AW-1:0]][EW-1:PRIO_W];
            channel_priority_o[k*PRIO_W +: PRIO_W] =
                mem[k][rd_ptr_q[k][AW-1:0]][PRIO_W-1:0];
            occupancy_o[k*OW +: OW] = wr_ptr_q[k] - rd_ptr_q[k];
        end
    end

    assign accept_cnt_o = cnt_q;

endmodule
